// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth sequencer.
// The control word is decoded from a state so the FSM can register it alongside the state.
package booth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CHECK,
    ST_ADD,
    ST_SUB,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int unsigned BOOTH_N = 12;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam logic ADD_SEL = 1'b1;
  localparam logic SUB_SEL = 1'b0;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic load_add;
    logic add_sub;
    logic shift;
    logic busy;
    logic done;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != ST_IDLE);
    case (s)
      ST_LOAD_A: c.load_a = 1'b1;
      ST_LOAD_B: c.load_b = 1'b1;
      ST_ADD: begin
        c.load_add = 1'b1;
        c.add_sub  = ADD_SEL;
      end
      ST_SUB: begin
        c.load_add = 1'b1;
        c.add_sub  = SUB_SEL;
      end
      ST_SHIFT:  c.shift = 1'b1;
      ST_DONE:   c.done  = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth sequencer: synchronous clear, increment,
// and a flag marking the final iteration (N-1).
module booth_iter_counter #(
  parameter int unsigned N     = 12,
  parameter int unsigned CNT_W = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(N - 1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Moore FSM sequencing a radix-2 Booth datapath: load A, load B, then N
// check/add-or-subtract/shift iterations followed by a one-cycle done pulse.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter  int unsigned N     = BOOTH_N,
  localparam int unsigned CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       Q_LSB,
  output logic             load_A,
  output logic             load_B,
  output logic             load_add,
  output logic             add_sub,
  output logic             shift_HQ_LQ_Q_1,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] w_cnt;
  logic             w_last;
  logic             w_clr;
  logic             w_inc;

  function automatic state_t next_state(input state_t s, input logic go,
                                        input logic [1:0] q, input logic last);
    state_t n;
    n = s;
    case (s)
      ST_IDLE:   if (go) n = ST_LOAD_A;
      ST_LOAD_A: n = ST_LOAD_B;
      ST_LOAD_B: n = ST_CHECK;
      ST_CHECK: begin
        if (q == BOOTH_ADD)      n = ST_ADD;
        else if (q == BOOTH_SUB) n = ST_SUB;
        else                     n = ST_SHIFT;
      end
      ST_ADD:    n = ST_SHIFT;
      ST_SUB:    n = ST_SHIFT;
      ST_SHIFT:  n = last ? ST_DONE : ST_CHECK;
      ST_DONE:   n = ST_IDLE;
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

  // Control word is registered from the next state, so it always equals decode(r_state).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= next_state(r_state, start, Q_LSB, w_last);
      r_ctrl  <= decode_ctrl(next_state(r_state, start, Q_LSB, w_last));
    end
  end

  assign w_clr = (r_state == ST_LOAD_B);
  assign w_inc = (r_state == ST_SHIFT) && !w_last;

  booth_iter_counter #(
    .N    (N),
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_cnt (w_cnt),
    .o_last(w_last)
  );

  assign load_A          = r_ctrl.load_a;
  assign load_B          = r_ctrl.load_b;
  assign load_add        = r_ctrl.load_add;
  assign add_sub         = r_ctrl.add_sub;
  assign shift_HQ_LQ_Q_1 = r_ctrl.shift;
  assign busy            = r_ctrl.busy;
  assign done            = r_ctrl.done;
  assign iter            = w_cnt;

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    $onehot0({load_A, load_B, load_add, shift_HQ_LQ_Q_1}));

  a_last_shift: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_SHIFT && w_last) |=> (r_state == ST_DONE));

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl driving a behavioural Booth datapath;
// expectations come from plain signed multiplication and Booth pair costs.
module tb_booth_seq_ctrl;

  localparam int N     = 12;
  localparam int CNT_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       Q_LSB;
  logic             load_A, load_B, load_add, add_sub, shift, busy, done;
  logic [CNT_W-1:0] iter;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .Q_LSB          (Q_LSB),
    .load_A         (load_A),
    .load_B         (load_B),
    .load_add       (load_add),
    .add_sub        (add_sub),
    .shift_HQ_LQ_Q_1(shift),
    .busy           (busy),
    .done           (done),
    .iter           (iter)
  );

  // Behavioural datapath reacting to the strobes
  logic [N-1:0] A_in = '0, B_in = '0;
  logic [N-1:0] dA = '0, dHQ = '0, dQ = '0;
  logic         dQ1 = 1'b0;
  logic         alt_ph = 1'b0;
  bit           alt_mode = 1'b0;

  always @(posedge clk) begin
    if (load_A) dA <= A_in;
    if (load_B) begin
      dQ <= B_in; dHQ <= '0; dQ1 <= 1'b0; alt_ph <= 1'b0;
    end
    if (load_add) dHQ <= add_sub ? dHQ + dA : dHQ - dA;
    if (shift) begin
      {dHQ, dQ, dQ1} <= {dHQ[N-1], dHQ, dQ};
      alt_ph <= ~alt_ph;
    end
  end

  assign Q_LSB = alt_mode ? (alt_ph ? 2'b10 : 2'b01) : {dQ[0], dQ1};

  typedef struct {
    int             lat;
    logic [2*N-1:0] y;
    bit             chk_y;
    int             n_add;
    int             n_sub;
    bit             chk_alt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   hold_mode = 1'b0;
  int   last_done_c = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input bit alt);
    exp_t e;
    logic signed [N-1:0] sa, sb;
    longint p;
    bit prev;
    sa = a; sb = b;
    p  = longint'(sa) * longint'(sb);
    e.y = p[2*N-1:0];
    e.chk_y = !alt;
    e.chk_alt = alt;
    e.n_add = 0; e.n_sub = 0;
    if (alt) begin
      e.lat = 3 + 3 * N; e.n_add = N / 2; e.n_sub = N / 2;
    end else begin
      e.lat = 3; prev = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!b[i] && prev)      begin e.n_add++; e.lat += 3; end
        else if (b[i] && !prev) begin e.n_sub++; e.lat += 3; end
        else                    e.lat += 2;
        prev = b[i];
      end
    end
    return e;
  endfunction

  // Monitor
  int job_c = 0, m_add = 0, m_sub = 0, m_shift = 0, last_as = -1;
  bit alt_bad = 1'b0, done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done_prev) begin
        chk("done_single_pulse", done, 0);
        chk("busy_after_done", busy, 0);
      end
      if (load_A) begin
        if (hold_mode && last_done_c > 0) chk("restart_gap", cyc - last_done_c, 2);
        job_c = cyc; m_add = 0; m_sub = 0; m_shift = 0; last_as = -1; alt_bad = 1'b0;
      end
      if (load_add) begin
        if (add_sub) m_add++; else m_sub++;
        if (last_as == int'(add_sub)) alt_bad = 1'b1;
        last_as = int'(add_sub);
      end
      if (shift) m_shift++;
      if (done) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - job_c + 1, e.lat);
          chk("shift_count", m_shift, N);
          chk("add_count", m_add, e.n_add);
          chk("sub_count", m_sub, e.n_sub);
          if (e.chk_y)   chk("product_Y", {dHQ, dQ}, e.y);
          if (e.chk_alt) chk("add_sub_alternates", alt_bad, 0);
        end
        last_done_c = cyc;
      end
      done_prev = done;
    end
  end

  task automatic wait_done(input bit pulse, input bit keep, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pulse) start = 1'($urandom_range(0, 1));
      if (done) begin
        if (!keep) start = 1'b0;
        ok = 1'b1;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL done_timeout: got no done in 200 cycles expected done");
  endtask

  task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit alt, input bit pulse);
    bit ok;
    @(negedge clk);
    A_in = a; B_in = b; alt_mode = alt;
    q.push_back(model(a, b, alt));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(pulse, 1'b0, ok);
  endtask

  function automatic logic [N-1:0] rand_a();
    logic [N-1:0] a;
    a = N'($urandom);
    if (a == 12'h800) a = 12'h801;
    return a;
  endfunction

  initial begin
    bit ok;
    bit seen;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {load_A, load_B, load_add, add_sub, shift, busy, done, iter}, 0);
    rst = 1'b0;

    // Abort a job during the 5th iteration
    @(negedge clk);
    A_in = 12'd15; B_in = 12'd3; alt_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (iter == CNT_W'(4)) begin seen = 1'b1; break; end
    end
    chk("reach_iter4", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", {load_A, load_B, load_add, add_sub, shift, busy, done, iter}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", busy, 0);

    run_job(12'd15, 12'd3, 1'b0, 1'b0);
    run_job(rand_a(), 12'd0, 1'b0, 1'b0);
    run_job(rand_a(), N'($urandom), 1'b1, 1'b0);
    run_job(12'hFF9, 12'd5, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) run_job(rand_a(), N'($urandom), 1'b0, 1'b1);

    // start held high: three back-to-back jobs on the same operands
    @(negedge clk);
    A_in = rand_a(); B_in = N'($urandom); alt_mode = 1'b0;
    hold_mode = 1'b1; last_done_c = 0;
    for (int k = 0; k < 3; k++) q.push_back(model(A_in, B_in, 1'b0));
    start = 1'b1;
    for (int k = 0; k < 3; k++) wait_done(1'b0, (k < 2), ok);
    start = 1'b0;
    repeat (3) @(negedge clk);
    hold_mode = 1'b0;
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
FSM controller that sequences the radix-2 Booth datapath `mult_with_no_fsm`, replacing hand-driven control strobes.
- Accepts a start request and issues `load_A` then `load_B`.
- Runs exactly N add/subtract/shift iterations steered by the datapath's `Q_LSB` pair, then pulses `done`.
- Sits between the top-level requester and the datapath instance; it never touches operand or result buses.

Parameters:
- N, 12, operand width and iteration count; must match the datapath's N (N >= 2).
- CNT_W, $clog2(N), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Q_LSB  input  2  {Q[0], Q_-1} from the datapath; sampled in CHECK.
- load_A  output  1  datapath strobe: load multiplicand register.
- load_B  output  1  datapath strobe: load multiplier Q and clear HQ/Q_-1.
- load_add  output  1  datapath strobe: write adder result into HQ.
- add_sub  output  1  adder select: 1 = add A, 0 = subtract A.
- shift_HQ_LQ_Q_1  output  1  datapath strobe: arithmetic right shift of {HQ,Q,Q_-1}.
- busy  output  1  high from LOAD_A through DONE inclusive.
- done  output  1  one-cycle pulse; Y is valid in this cycle and stays valid until the next start.
- iter  output  CNT_W  current iteration index (debug/verification).

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state = IDLE, counter = 0. All outputs are 0 (load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1, busy, done, iter).
- rst asserted mid-operation: IDLE on the next edge, all outputs 0, no done. The datapath content is then undefined until the next start.
- States: IDLE, LOAD_A, LOAD_B, CHECK, ADD, SUB, SHIFT, DONE. Outputs are Moore-decoded from the state register; no output depends combinationally on inputs.
- IDLE: start=1 -> LOAD_A; otherwise stay.
- LOAD_A: load_A=1 -> LOAD_B. The requester holds A stable during this cycle.
- LOAD_B: load_B=1, counter cleared -> CHECK. The requester holds B stable during this cycle.
- CHECK: no strobes. Transition on Q_LSB:
  - 01 -> ADD
  - 10 -> SUB
  - 00 or 11 -> SHIFT
- ADD: load_add=1, add_sub=1 -> SHIFT.
- SUB: load_add=1, add_sub=0 -> SHIFT.
- add_sub is 0 in every state other than ADD.
- SHIFT: shift_HQ_LQ_Q_1=1.
  - If counter == N-1 -> DONE.
  - Else counter += 1 -> CHECK.
- DONE: done=1 -> IDLE unconditionally. start is ignored here, so back-to-back jobs cost one IDLE cycle.
- start while busy: ignored; no queuing.
- Latency, counted from the edge where start is sampled in IDLE:
  - Per-iteration cost: 2 cycles for Q_LSB 00/11, 3 cycles for 01/10.
  - DONE occupies cycle 3 + sum(iteration costs).
  - Minimum (all 00/11): done at cycle 2N+3. Maximum (all 01/10): done at cycle 3N+3.
- Strobe exclusivity: at most one of load_A, load_B, load_add, shift is high in any cycle (assertion).
- Iteration count: exactly N SHIFT cycles per job (assertion).

Decomposition:
- Package `booth_pkg`:
  - state enum (3-bit),
  - default N = 12,
  - Q_LSB encodings BOOTH_ADD = 2'b01 and BOOTH_SUB = 2'b10,
  - ADD_SEL = 1'b1 and SUB_SEL = 1'b0.
- Sub-module `booth_iter_counter`: clear, increment, `last` flag at N-1. The FSM stays in `booth_seq_ctrl`.

Test Plan:
- Reset mid-run: rst asserted for one cycle during the 5th iteration -> next cycle IDLE, all outputs 0, no done. A fresh start with A=15, B=3 then completes normally with Y=45.
- A=15, B=3 (N=12), connected to the real datapath:
  - Q_LSB sequence 10, 11, 01, then 00 x9.
  - Exactly one SUB and one ADD, 12 shifts.
  - done at cycle 29; Y = 24'd45.
- B=0 (Q_LSB always 00): no load_add ever; done at cycle 27 (2N+3); Y=0.
- Q_LSB forced by the bench model to alternate 01/10 every iteration:
  - 12 load_add pulses with add_sub alternating 1/0;
  - done at cycle 39 (3N+3).
- A = 12'hFF9 (-7), B=5: Y = 24'hFFFFDD (-35); done is a single-cycle pulse; busy drops in the cycle after done.
- start held high continuously: jobs restart with exactly one IDLE cycle between done and the next load_A. start pulses during busy cause no change in the state trace.
